// File: rtl/st7735_spi_tx.sv
// rtl/st7735_spi_tx.sv - SPI mode 0 byte serialiser driving ST7735 CS/DC/MOSI/LCD_CLK
module st7735_spi_tx #(
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic       SYSTEM_CLK,
    input  logic       RESET_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_DC,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       BUSY,
    output logic       CS,
    output logic       DC,
    output logic       MOSI,
    output logic       LCD_CLK
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_GAP,
        ST_CSH
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] CSH_LAST = 8'(CS_HIGH_CYCLES - 1);

    state_t     state;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt;
    logic [7:0] div_cnt;
    logic [7:0] csh_cnt;
    logic       cs_q;
    logic       dc_q;
    logic       mosi_q;
    logic       lcd_clk_q;

    // Ready only in the two states that can load a byte; never while LCD_CLK is high
    assign TX_READY = RESET_N && ((state == ST_IDLE) || (state == ST_GAP));
    assign BUSY     = RESET_N && (state != ST_IDLE);
    assign CS       = cs_q;
    assign DC       = dc_q;
    assign MOSI     = mosi_q;
    assign LCD_CLK  = lcd_clk_q;

    // Frame sequencer: load, clock out 8 bits MSB-first, then either chain or release CS
    always_ff @(posedge SYSTEM_CLK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            csh_cnt   <= '0;
            cs_q      <= 1'b1;
            dc_q      <= 1'b0;
            mosi_q    <= 1'b0;
            lcd_clk_q <= 1'b0;
        end else if (((state == ST_IDLE) || (state == ST_GAP)) && TX_VALID) begin
            // Load: bit 7 and DC are set up together with CS falling (or staying low in GAP)
            shift_q   <= TX_DATA[6:0];
            mosi_q    <= TX_DATA[7];
            dc_q      <= TX_DC;
            cs_q      <= 1'b0;
            lcd_clk_q <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            state     <= ST_LOW;
        end else begin
            case (state)
                ST_IDLE: begin
                    cs_q      <= 1'b1;
                    lcd_clk_q <= 1'b0;
                end
                ST_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        lcd_clk_q <= 1'b1;
                        div_cnt   <= '0;
                        state     <= ST_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        lcd_clk_q <= 1'b0;
                        div_cnt   <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_GAP;
                        end else begin
                            // Next bit is presented on the falling edge
                            shift_q <= {shift_q[5:0], 1'b0};
                            mosi_q  <= shift_q[6];
                            bit_cnt <= bit_cnt + 3'd1;
                            state   <= ST_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    cs_q    <= 1'b1;
                    csh_cnt <= '0;
                    state   <= ST_CSH;
                end
                ST_CSH: begin
                    if (csh_cnt == CSH_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        csh_cnt <= csh_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_st7735_spi_tx.sv
// tb/tb_st7735_spi_tx.sv - self-checking bench for st7735_spi_tx at CLK_DIV=2 and CLK_DIV=1
module tb_st7735_spi_tx;

    logic       system_clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data [2];
    logic [1:0] tx_dc;
    logic [1:0] tx_valid;
    logic [1:0] tx_ready;
    logic [1:0] busy;
    logic [1:0] cs;
    logic [1:0] dc;
    logic [1:0] mosi;
    logic [1:0] lcd_clk;

    int   vec    = 0;
    int   miss   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int   t;
        logic b;
        logic dc;
    } ev_t;

    always #5 system_clk = ~system_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int D = (k == 0) ? 2 : 1;
        localparam int H = 2;

        st7735_spi_tx #(.CLK_DIV(D), .CS_HIGH_CYCLES(H)) dut (
            .SYSTEM_CLK (system_clk),
            .RESET_N    (reset_n),
            .TX_DATA    (tx_data[k]),
            .TX_DC      (tx_dc[k]),
            .TX_VALID   (tx_valid[k]),
            .TX_READY   (tx_ready[k]),
            .BUSY       (busy[k]),
            .CS         (cs[k]),
            .DC         (dc[k]),
            .MOSI       (mosi[k]),
            .LCD_CLK    (lcd_clk[k])
        );

        logic       acc_seen;
        logic       rst_seen;
        logic [7:0] data_seen;
        logic       dc_seen;
        ev_t        q[$];
        int         cyc      = 0;
        int         last_acc = 0;
        int         rises    = 0;
        bit         has_acc  = 1'b0;
        logic       prev_lcd = 1'b0;
        logic       prev_mosi = 1'b0;
        logic       prev_dc  = 1'b0;

        always_ff @(posedge system_clk) begin
            acc_seen  <= tx_valid[k] && tx_ready[k];
            rst_seen  <= !reset_n;
            data_seen <= tx_data[k];
            dc_seen   <= tx_dc[k];
        end

        always begin
            ev_t e;
            @(posedge system_clk);
            #1;
            cyc++;
            if (mon_en) begin
                if (rst_seen) begin
                    q.delete();
                    has_acc = 1'b0;
                end else if (acc_seen) begin
                    if (has_acc)
                        chk($sformatf("accept_spacing%0d", k),
                            32'((cyc - last_acc == 16*D + 1) || (cyc - last_acc >= 16*D + 2 + H)), 32'd1);
                    for (int n = 0; n < 8; n++) begin
                        e.t  = cyc + (2*n + 1) * D;
                        e.b  = data_seen[7-n];
                        e.dc = dc_seen;
                        q.push_back(e);
                    end
                    has_acc  = 1'b1;
                    last_acc = cyc;
                end
                if (lcd_clk[k] === 1'b1 && prev_lcd === 1'b0) begin
                    rises++;
                    if (q.size() == 0) begin
                        chk($sformatf("unexpected_rise%0d", k), 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rise_time%0d", k), 32'(cyc), 32'(e.t));
                        chk($sformatf("rise_mosi%0d", k), 32'(mosi[k]), 32'(e.b));
                        chk($sformatf("rise_dc%0d", k), 32'(dc[k]), 32'(e.dc));
                    end
                end
                if (q.size() > 0 && cyc > q[0].t) begin
                    chk($sformatf("missed_rise%0d", k), 32'(cyc), 32'(q[0].t));
                    void'(q.pop_front());
                end
                if (mosi[k] !== prev_mosi || dc[k] !== prev_dc)
                    chk($sformatf("data_change_clk%0d", k), 32'(lcd_clk[k]), 32'd0);
                chk($sformatf("ready_while_clk%0d", k), 32'(tx_ready[k] && lcd_clk[k]), 32'd0);
                chk($sformatf("cs%0d", k), 32'(cs[k]),
                    32'(!(has_acc && cyc <= last_acc + 16*D)));
                chk($sformatf("busy%0d", k), 32'(busy[k]),
                    32'(reset_n && has_acc && cyc <= last_acc + 16*D + H));
            end
            prev_lcd  = lcd_clk[k];
            prev_mosi = mosi[k];
            prev_dc   = dc[k];
        end
    end

    function automatic int rises_of(input int k);
        return (k == 0) ? g[0].rises : g[1].rises;
    endfunction

    // Offer a byte at a falling edge and return at the falling edge after it is accepted
    task automatic send(input int k, input logic [7:0] data, input logic dcv);
        bit ok = 1'b0;
        tx_data[k]  = data;
        tx_dc[k]    = dcv;
        tx_valid[k] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (tx_ready[k]) begin
                ok = 1'b1;
                @(negedge system_clk);
                break;
            end
            @(negedge system_clk);
        end
        chk($sformatf("accept_timeout%0d", k), 32'(ok), 32'd1);
        chk($sformatf("load_cs%0d", k), 32'(cs[k]), 32'd0);
        chk($sformatf("load_mosi%0d", k), 32'(mosi[k]), 32'(data[7]));
        chk($sformatf("load_dc%0d", k), 32'(dc[k]), 32'(dcv));
    endtask

    task automatic idle(input int k);
        tx_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge system_clk);
            if (!busy[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("idle_timeout%0d", k), 32'(ok), 32'd1);
    endtask

    initial begin
        int r0;
        bit ok;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tx_data[k]  = 8'h00;
            tx_dc[k]    = 1'b0;
            tx_valid[k] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(tx_ready[k]), 32'd0);
            chk("rst_cs", 32'(cs[k]), 32'd1);
            chk("rst_lcd", 32'(lcd_clk[k]), 32'd0);
            chk("rst_mosi", 32'(mosi[k]), 32'd0);
            chk("rst_dc", 32'(dc[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
        end
        mon_en  = 1'b1;
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk("ready_after_rst", 32'(tx_ready[k]), 32'd1);
        @(negedge system_clk);

        // Single command byte
        r0 = rises_of(0);
        send(0, 8'h81, 1'b0);
        idle(0);
        wait_idle(0);
        chk("single_rises", 32'(rises_of(0) - r0), 32'd8);

        // Back-to-back bytes share one CS window
        r0 = rises_of(0);
        send(0, 8'h2A, 1'b0);
        send(0, 8'hA5, 1'b1);
        idle(0);
        wait_idle(0);
        chk("b2b_rises", 32'(rises_of(0) - r0), 32'd16);

        // Upstream stall after GAP
        r0 = rises_of(0);
        send(0, 8'h5C, 1'b1);
        idle(0);
        repeat (16*2 + 10) @(negedge system_clk);
        send(0, 8'h11, 1'b0);
        idle(0);
        wait_idle(0);
        chk("stall_rises", 32'(rises_of(0) - r0), 32'd16);

        // Randomised streams with random upstream gaps
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) begin
                send(k, 8'($urandom), 1'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    idle(k);
                    repeat ($urandom_range(0, 40)) @(negedge system_clk);
                end
            end
            idle(k);
            wait_idle(k);
        end

        // Reset after the third LCD_CLK rise of a byte
        r0 = rises_of(0);
        send(0, 8'hB7, 1'b1);
        idle(0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rises_of(0) >= r0 + 3) begin
                ok = 1'b1;
                break;
            end
            @(negedge system_clk);
        end
        chk("third_rise_timeout", 32'(ok), 32'd1);
        reset_n = 1'b0;
        @(negedge system_clk);
        chk("abort_cs", 32'(cs[0]), 32'd1);
        chk("abort_lcd", 32'(lcd_clk[0]), 32'd0);
        chk("abort_mosi", 32'(mosi[0]), 32'd0);
        chk("abort_dc", 32'(dc[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge system_clk);
        chk("abort_no_rises", 32'(rises_of(0) - r0), 32'd3);
        send(0, 8'h3C, 1'b0);
        idle(0);
        wait_idle(0);
        chk("after_abort_rises", 32'(rises_of(0) - r0), 32'd11);

        // CLK_DIV=1 back-to-back corner
        r0 = rises_of(1);
        send(1, 8'hFF, 1'b0);
        send(1, 8'h00, 1'b1);
        idle(1);
        wait_idle(1);
        chk("div1_rises", 32'(rises_of(1) - r0), 32'd16);

        repeat (4) @(negedge system_clk);
        chk("pending_events0", 32'(g[0].q.size()), 32'd0);
        chk("pending_events1", 32'(g[1].q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
